vector_packer: RTL and testbench
================================

Name: vector_packer

Overview:
- Streams IEEE-754 single-precision words in one at a time over a valid/ready handshake.
- Packs them into a VLEN-wide flat vector bus: element i at bits [32*i +: 32].
- Presents the completed vector to downstream vector consumers (vector sum, dot product) over a second valid/ready handshake.
- Short vectors, terminated early by in_last, are zero-padded with +0.0 so reductions stay correct.

Parameters:
- VLEN, 4, number of 32-bit elements per packed vector; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_data  input  32  float element
- in_valid  input  1  in_data valid
- in_last  input  1  qualifies in_data as final element of the current vector; sampled only on an accepted beat
- in_ready  output  1  packer can accept an element
- vector  output  32*VLEN  packed vector; element i at [32*i +: 32]
- out_valid  output  1  vector complete and stable
- out_ready  input  1  downstream consumes vector
- elem_count  output  8  number of real (non-padded) elements in the presented vector, 1..VLEN

Behaviour:
- Reset (async assert, sync release):
  - state=FILL, write index idx=0.
  - vector=0, out_valid=0, elem_count=0.
  - in_ready=1 from the first clock edge after reset deasserts.
- State FILL:
  - in_ready=1, out_valid=0.
  - Accept occurs when in_valid && in_ready on a rising edge: vector[32*idx +: 32] <= in_data, then idx increments.
- FILL -> FULL:
  - Taken on an accepted beat when idx==VLEN-1 or in_last=1.
  - Same edge: every slot j>idx is written 32'h00000000, elem_count <= idx+1, idx <= 0.
- FILL with no accept: vector and idx hold.
- State FULL:
  - out_valid=1, in_ready=0; vector and elem_count are stable, so in_data is not accepted.
- FULL -> FILL:
  - Taken on an edge with out_ready=1.
  - vector retains its contents, which are overwritten slot by slot during the next fill.
  - elem_count holds until the next FULL entry.
- Latency:
  - out_valid rises on the edge that accepts the last element, i.e. 0 cycles after the final beat, visible the next cycle.
  - Minimum throughput is VLEN+1 cycles per vector (one drain cycle, no fill/drain overlap).
- Boundary conditions:
  - in_last on the first element: elem_count=1, slots 1..VLEN-1 zero.
  - in_last on slot VLEN-1: same as a normal full vector, no padding.
  - VLEN=1: every accepted beat goes straight to FULL.
  - out_ready held high in FILL: ignored.
  - in_valid held high in FULL: not accepted, upstream data must be held (standard valid/ready: valid never depends on ready).
  - Reset mid-fill or in FULL: the partial or pending vector is discarded and all outputs return to reset values immediately.
- No arithmetic on data: bits pass through unchanged (NaN, Inf and denormals preserved).
- Padding is +0.0, so a downstream float sum of the vector equals the sum of the real elements.

Test Plan:
- VLEN=4, stream 3F800000, 40000000, 40400000, 40800000 with in_valid continuously high -> after the 4th accept: out_valid=1, vector=40800000_40400000_40000000_3F800000, elem_count=4, in_ready=0.
- Same data with out_ready held low for 5 cycles while in_valid stays high with 41000000 -> vector unchanged and no accept. Then out_ready=1 for one cycle -> next cycle in_ready=1 and 41000000 is accepted into slot 0.
- VLEN=4, send 3F800000 then 40000000 with in_last=1 -> vector=00000000_00000000_40000000_3F800000, elem_count=2.
- in_last on the first beat with BF800000 -> elem_count=1, slots 1..3 = 0. Feeding this vector to the vector sum gives BF800000.
- Assert rst after 2 accepts -> out_valid=0 and vector=0 asynchronously. After release, a fresh 4-element stream packs from slot 0.
- Random in_valid/out_ready gaps over 1000 vectors with random in_last -> scoreboard matches every element and pad. No element is lost or duplicated, and in_ready and out_valid are never both high.

Source files
------------

// File: rtl/vector_packer.sv
// Packs a stream of 32-bit float words into a VLEN-element flat vector and
// hands the finished vector downstream; short vectors are padded with +0.0.
module vector_packer #(
    parameter int VLEN = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [32*VLEN-1:0]     vector,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             elem_count
);

    typedef enum logic {S_FILL, S_FULL} state_t;

    state_t              r_state;
    logic [7:0]          r_idx;
    logic [32*VLEN-1:0]  r_vector;
    logic [7:0]          r_elem_count;
    logic                r_in_ready;
    logic                r_out_valid;

    logic                w_accept;
    logic                w_close;

    assign w_accept = in_valid && r_in_ready;
    assign w_close  = in_last || (r_idx == 8'(VLEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_FILL;
            r_idx        <= '0;
            r_vector     <= '0;
            r_elem_count <= '0;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        // Closing beat also clears every slot above it, so stale
                        // data from an earlier longer vector never leaks out.
                        for (int j = 0; j < VLEN; j++) begin
                            if (j == int'(r_idx))
                                r_vector[32*j +: 32] <= in_data;
                            else if (w_close && (j > int'(r_idx)))
                                r_vector[32*j +: 32] <= 32'h0000_0000;
                        end
                        if (w_close) begin
                            r_state      <= S_FULL;
                            r_idx        <= '0;
                            r_elem_count <= r_idx + 8'd1;
                            r_in_ready   <= 1'b0;
                            r_out_valid  <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 8'd1;
                        end
                    end
                end
                S_FULL: begin
                    if (out_ready) begin
                        r_state     <= S_FILL;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign vector     = r_vector;
    assign elem_count = r_elem_count;

endmodule

// File: tb/tb_vector_packer.sv
// Scoreboard bench for vector_packer (VLEN=4): directed vectors followed by
// random handshake gaps; a monitor pops expected vectors on each output handshake.
module tb_vector_packer;

    localparam int VLEN = 4;
    localparam int VW   = 32 * VLEN;

    logic            clk;
    logic            rst;
    logic [31:0]     in_data;
    logic            in_valid;
    logic            in_last;
    logic            in_ready;
    logic [VW-1:0]   vector;
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      elem_count;

    typedef struct {
        logic [VW-1:0] vec;
        logic [7:0]    cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic done_rand;

    vector_packer #(.VLEN(VLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .vector     (vector),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .elem_count (elem_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [VW-1:0] v, input logic [7:0] c);
        exp_t e;
        e.vec = v;
        e.cnt = c;
        exp_q.push_back(e);
    endtask

    // Present one beat and hold it until the DUT takes it (bounded).
    task automatic send_beat(input logic [31:0] d, input logic l);
        int   n;
        logic acc;
        n = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        forever begin
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got no accept for %h expected accept within 200 cycles", d);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain_one();
        chk("drain_out_valid", VW'(out_valid), VW'(1'b1));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // Monitor: compares the presented vector whenever a handshake will occur.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (in_ready && out_valid) begin
                    checks++;
                    errors++;
                    $display("FAIL ready_valid_overlap: got in_ready=1 out_valid=1 expected not both");
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_vector: got %h expected no vector", vector);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_vector", vector, e.vec);
                        chk("sb_elem_count", VW'(elem_count), VW'(e.cnt));
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0]   d[VLEN];
        logic [VW-1:0] v;
        int            len;
        logic          lst;
        int            n;

        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        done_rand = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", VW'(out_valid), '0);
        chk("rst_vector", vector, '0);
        chk("rst_elem_count", VW'(elem_count), '0);
        chk("rst_in_ready", VW'(in_ready), '0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready_before_edge", VW'(in_ready), '0);
        @(posedge clk); #1;
        chk("rel_in_ready_after_edge", VW'(in_ready), VW'(1'b1));

        // Full vector, back-to-back beats.
        push_exp(128'h40800000_40400000_40000000_3F800000, 8'd4);
        send_beat(32'h3F800000, 1'b0);
        send_beat(32'h40000000, 1'b0);
        send_beat(32'h40400000, 1'b0);
        send_beat(32'h40800000, 1'b0);
        chk("full_out_valid", VW'(out_valid), VW'(1'b1));
        chk("full_in_ready", VW'(in_ready), '0);
        chk("full_vector", vector, 128'h40800000_40400000_40000000_3F800000);
        chk("full_elem_count", VW'(elem_count), VW'(8'd4));

        // Back-pressure: upstream holds 41000000 while downstream stalls.
        push_exp(128'h00000000_00000000_00000000_41000000, 8'd1);
        in_data  = 32'h41000000;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_vector", vector, 128'h40800000_40400000_40000000_3F800000);
            chk("stall_in_ready", VW'(in_ready), '0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_in_ready", VW'(in_ready), VW'(1'b1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("held_beat_vector", vector, 128'h00000000_00000000_00000000_41000000);
        chk("held_beat_count", VW'(elem_count), VW'(8'd1));
        drain_one();

        // Short vector with out_ready held high during the fill.
        push_exp(128'h00000000_00000000_40000000_3F800000, 8'd2);
        out_ready = 1'b1;
        send_beat(32'h3F800000, 1'b0);
        send_beat(32'h40000000, 1'b1);
        chk("short_vector", vector, 128'h00000000_00000000_40000000_3F800000);
        chk("short_count", VW'(elem_count), VW'(8'd2));
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("short_drained", VW'(out_valid), '0);

        // in_last on first beat.
        push_exp(128'h00000000_00000000_00000000_BF800000, 8'd1);
        send_beat(32'hBF800000, 1'b1);
        chk("single_vector", vector, 128'h00000000_00000000_00000000_BF800000);
        chk("single_count", VW'(elem_count), VW'(8'd1));
        drain_one();

        // in_last on the final slot, NaN/Inf/denormal pass-through.
        push_exp(128'h7F800000_00000001_7FC00001_FF800000, 8'd4);
        send_beat(32'hFF800000, 1'b0);
        send_beat(32'h7FC00001, 1'b0);
        send_beat(32'h00000001, 1'b0);
        send_beat(32'h7F800000, 1'b1);
        chk("last_slot_count", VW'(elem_count), VW'(8'd4));
        drain_one();

        // Reset mid-fill discards the partial vector.
        send_beat(32'h11111111, 1'b0);
        send_beat(32'h22222222, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_vector", vector, '0);
        chk("midrst_out_valid", VW'(out_valid), '0);
        chk("midrst_count", VW'(elem_count), '0);
        chk("midrst_in_ready", VW'(in_ready), '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("postrst_in_ready", VW'(in_ready), VW'(1'b1));
        push_exp(128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 8'd4);
        send_beat(32'hAAAAAAAA, 1'b0);
        send_beat(32'hBBBBBBBB, 1'b0);
        send_beat(32'hCCCCCCCC, 1'b0);
        send_beat(32'hDDDDDDDD, 1'b0);
        chk("postrst_vector", vector, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
        drain_one();

        // Random gaps on both handshakes.
        fork
            begin
                for (int k = 0; k < 1000; k++) begin
                    len = $urandom_range(1, VLEN);
                    lst = (len < VLEN) ? 1'b1 : 1'($urandom_range(0, 1));
                    v = '0;
                    for (int i = 0; i < VLEN; i++) begin
                        d[i] = $urandom();
                        if (i < len) v[32*i +: 32] = d[i];
                    end
                    push_exp(v, 8'(len));
                    for (int i = 0; i < len; i++) begin
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge clk); #1;
                        end
                        send_beat(d[i], (i == len - 1) ? lst : 1'b0);
                    end
                end
                done_rand = 1'b1;
            end
            begin
                while (!done_rand) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join

        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b0;
        chk("queue_empty", VW'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
